dac_spi_ctrl: RTL



---
 rtl/dac_spi_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dac_spi_ctrl.sv
// dac_spi_ctrl -- serial DAC controller fed by the DAC instruction queue.
//
// Pops one {channel, data} instruction at a time (one-cycle rd_ack_out
// pulse) and shifts it out as a 32-bit SPI write frame, MSB first. The DAC
// samples dac_din_out on the falling edge of dac_sclk_out. After reset an
// optional internal-reference-enable frame goes out before any queue data.
//
// Ports:
//   clk_in         system clock
//   reset_in       asynchronous, active-high reset
//   data_in        instruction data from queue (W_DATA bits, left-justified)
//   chan_in        instruction channel from queue (W_CHS bits)
//   data_valid_in  queue output valid
//   rd_ack_out     one-cycle pop pulse to queue
//   dac_nsync_out  SPI frame select, active-low
//   dac_sclk_out   SPI clock, idles high
//   dac_din_out    SPI data, MSB first
//   busy_out       high while a frame or the inter-frame gap is in progress
module dac_spi_ctrl #(
  parameter int         W_DATA    = 16,
  parameter int         W_CHS     = 3,
  parameter int         CLK_HALF  = 2,
  parameter int         T_SYNC_HI = 4,
  parameter logic [3:0] CMD_WR    = 4'b0011,
  parameter bit         INIT_REF  = 1'b1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_DATA-1:0] data_in,
  input  logic [W_CHS-1:0]  chan_in,
  input  logic              data_valid_in,
  output logic              rd_ack_out,
  output logic              dac_nsync_out,
  output logic              dac_sclk_out,
  output logic              dac_din_out,
  output logic              busy_out
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SHIFT, ST_SYNC_HI} state_t;

  localparam logic [31:0] INIT_FRAME = 32'h0800_0001;
  localparam logic [15:0] DIV_MAX    = 16'(CLK_HALF - 1);
  localparam logic [15:0] GAP_MAX    = 16'(T_SYNC_HI - 1);
  localparam state_t      RST_STATE  = INIT_REF ? ST_INIT : ST_IDLE;

  state_t      r_state;
  logic [31:0] r_shift;
  logic [4:0]  r_bit;
  logic [15:0] r_div;
  logic [15:0] r_gap;
  logic        r_rd_ack, r_nsync, r_sclk, r_din, r_busy;

  logic [15:0] w_data16;
  logic [3:0]  w_chan4;
  logic [31:0] w_frame;
  logic [31:0] w_load;

  // Data is left-justified into the 16-bit field; narrower DACs get zero fill
  assign w_data16 = 16'(data_in) << (16 - W_DATA);
  assign w_chan4  = 4'(chan_in);
  assign w_frame  = {4'h0, CMD_WR, w_chan4, w_data16, 4'h0};
  assign w_load   = (r_state == ST_INIT) ? INIT_FRAME : w_frame;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state  <= RST_STATE;
      r_shift  <= '0;
      r_bit    <= '0;
      r_div    <= '0;
      r_gap    <= '0;
      r_rd_ack <= 1'b0;
      r_nsync  <= 1'b1;
      r_sclk   <= 1'b1;
      r_din    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rd_ack <= 1'b0;
      case (r_state)
        ST_INIT, ST_IDLE: begin
          // INIT loads unconditionally; IDLE only on a valid queue word
          if (r_state == ST_INIT || data_valid_in) begin
            r_shift  <= w_load;
            r_din    <= w_load[31];
            r_nsync  <= 1'b0;
            r_sclk   <= 1'b1;
            r_div    <= '0;
            r_bit    <= '0;
            r_busy   <= 1'b1;
            r_rd_ack <= (r_state == ST_IDLE);
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_div != DIV_MAX) begin
            r_div <= r_div + 16'd1;
          end else begin
            r_div <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;                 // falling edge: DAC samples din
            end else if (r_bit == 5'd31) begin
              // end of last low phase: close the frame
              r_sclk  <= 1'b1;
              r_nsync <= 1'b1;
              r_din   <= 1'b0;
              r_gap   <= '0;
              r_state <= ST_SYNC_HI;
            end else begin
              // rising edge: present the next bit
              r_sclk  <= 1'b1;
              r_bit   <= r_bit + 5'd1;
              r_din   <= r_shift[30];
              r_shift <= {r_shift[30:0], 1'b0};
            end
          end
        end
        ST_SYNC_HI: begin
          if (r_gap == GAP_MAX) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 16'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_ack_out    = r_rd_ack;
  assign dac_nsync_out = r_nsync;
  assign dac_sclk_out  = r_sclk;
  assign dac_din_out   = r_din;
  assign busy_out      = r_busy;

endmodule
